// File: rtl/des_pkg.sv
// ---------------------------------------------------------------------------
// des_pkg
// Shared DES key-schedule constants for the encrypt and decrypt key paths.
//   PC1_TAB     : 56 source bit numbers (1 = key MSB) for Permuted Choice 1
//   PC2_TAB     : 48 source bit numbers (1 = C MSB) for Permuted Choice 2
//   DEC_ROT_ONE : bit n set when the step leaving subkey index n rotates C/D
//                 right by one position; clear means two positions
//   state_t     : scheduler control states
//   rotr28      : fixed-wire right rotate of a 28-bit half by 1 or 2
// ---------------------------------------------------------------------------
package des_pkg;

    localparam int DES_NROUNDS = 16;

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Index n undoes the left shift of encrypt round 16-n; rounds 16, 9 and 2
    // shift by one, so indices 0, 7 and 14 rotate by one. Index 15 is unused.
    localparam logic [DES_NROUNDS-1:0] DEC_ROT_ONE = 16'h4081;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bit 27 holds the first DES bit of the half, so a DES right rotate moves
    // the low bits up to the top.
    function automatic logic [27:0] rotr28(input logic [27:0] v, input logic one);
        return one ? {v[0], v[27:1]} : {v[1:0], v[27:2]};
    endfunction

endpackage

// File: rtl/des_dec_key_sched_if.sv
// ---------------------------------------------------------------------------
// des_dec_key_sched_if
// Key-load and subkey-stream channel of the DES decrypt key scheduler.
//   key_in/key_valid/key_ready         : 64-bit key load handshake
//   subkey/subkey_idx/subkey_valid/
//   subkey_ready                       : 48-bit subkey stream, K16 first
//   done                               : pulse after the last subkey
// master = scheduler side, slave = key source / subkey consumer side.
// ---------------------------------------------------------------------------
interface des_dec_key_sched_if;

    logic [63:0] key_in;
    logic        key_valid;
    logic        key_ready;
    logic [47:0] subkey;
    logic [3:0]  subkey_idx;
    logic        subkey_valid;
    logic        subkey_ready;
    logic        done;

    modport master (
        input  key_in, key_valid, subkey_ready,
        output key_ready, subkey, subkey_idx, subkey_valid, done
    );

    modport slave (
        output key_in, key_valid, subkey_ready,
        input  key_ready, subkey, subkey_idx, subkey_valid, done
    );

endinterface

// File: rtl/des_pc2.sv
// ---------------------------------------------------------------------------
// des_pc2
// Purely combinational DES Permuted Choice 2 (56 -> 48 bits).
//   i_cd  : {C, D}; bit 55 = C bit 1
//   o_key : subkey; bit 47 = PC-2 output bit 1
// ---------------------------------------------------------------------------
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] i_cd,
    output logic [47:0] o_key
);

    for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
        assign o_key[47-gi] = i_cd[56-PC2_TAB[gi]];
    end

endmodule

// File: rtl/des_dec_key_sched.sv
// ---------------------------------------------------------------------------
// des_dec_key_sched
// Iterative DES key scheduler emitting the 16 subkeys in decryption order
// (K16 first, K1 last). PC-1 is applied once at load; each accepted subkey
// rotates C and D right to step back one encrypt round.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : key load / subkey stream channel (master side)
// ---------------------------------------------------------------------------
module des_dec_key_sched
    import des_pkg::*;
#(
    parameter int NROUNDS = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    des_dec_key_sched_if.master        bus
);

    // The index counter is 4 bits wide; this cast only fits for 16 rounds.
    localparam logic [3:0] LAST_IDX = 4'(NROUNDS - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [3:0]  r_cnt;
    logic        r_done;
    logic        w_load;
    logic        w_xfer;
    logic        w_last;
    logic [55:0] w_pc1;
    logic [47:0] w_subkey;
    logic        w_unused_parity;

    // PC-1: the loaded C0/D0 equals C16/D16 (encrypt shifts total 28), so
    // K16 comes straight out of the load without a pre-rotation.
    for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
        assign w_pc1[55-gi] = bus.key_in[64-PC1_TAB[gi]];
    end

    // DES bits 8, 16, ..., 64 are parity and never reach the schedule.
    assign w_unused_parity = ^{bus.key_in[56], bus.key_in[48], bus.key_in[40],
                               bus.key_in[32], bus.key_in[24], bus.key_in[16],
                               bus.key_in[8],  bus.key_in[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_xfer       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.key_valid) begin
                    w_load       = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (bus.subkey_ready) begin
                    w_xfer = 1'b1;
                    if (r_cnt == LAST_IDX) begin
                        w_last       = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c    <= '0;
            r_d    <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_c   <= w_pc1[55:28];
                r_d   <= w_pc1[27:0];
                r_cnt <= '0;
            end else if (w_xfer) begin
                if (w_last) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                    r_c   <= rotr28(r_c, DEC_ROT_ONE[r_cnt]);
                    r_d   <= rotr28(r_d, DEC_ROT_ONE[r_cnt]);
                end
            end
        end
    end

    des_pc2 u_pc2 (
        .i_cd  ({r_c, r_d}),
        .o_key (w_subkey)
    );

    assign bus.key_ready    = (r_state == IDLE);
    assign bus.subkey_valid = (r_state == RUN);
    assign bus.subkey       = w_subkey;
    assign bus.subkey_idx   = r_cnt;
    assign bus.done         = r_done;

endmodule

// File: tb/tb_des_dec_key_sched.sv
module tb_des_dec_key_sched;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    des_dec_key_sched_if bus ();

    des_dec_key_sched #(.NROUNDS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference tables (FIPS 46-3) for an independent encrypt-direction model.
    int tb_pc1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                        10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                        63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                        14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int tb_pc2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                        23,19,12,4,26,8, 16,7,27,20,13,2,
                        41,52,31,37,47,55, 30,40,51,45,33,48,
                        44,49,39,56,34,53, 46,42,50,36,29,32};
    int tb_shift [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    logic [47:0] exp_k [16];
    logic [47:0] got_k [16];

    // Forward (encrypt) schedule K1..K16, stored reversed as decrypt order.
    task automatic model(input logic [63:0] key);
        logic [55:0] p;
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] k;
        for (int i = 0; i < 56; i++) p[55-i] = key[64-tb_pc1[i]];
        c = p[55:28];
        d = p[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < tb_shift[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) k[47-i] = cd[56-tb_pc2[i]];
            exp_k[15-r] = k;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at a negedge with the DUT idle. rmode=1 randomises subkey_ready.
    // hold=1 leaves key_valid high with a junk key during RUN and returns in
    // the done cycle so the caller's next key is taken in that same cycle.
    task automatic run_key(input string name, input logic [63:0] key, input bit rmode,
                           input bit hold, input logic [63:0] junk);
        int n;
        int cyc;
        bit stalled;
        bit rdy;
        logic [47:0] prev;
        model(key);
        chk({name, ":key_ready"}, 64'(bus.key_ready), 64'd1);
        bus.key_in    = key;
        bus.key_valid = 1'b1;
        @(negedge clk);
        chk({name, ":latency_valid"}, 64'(bus.subkey_valid), 64'd1);
        if (hold) bus.key_in = junk;
        else      bus.key_valid = 1'b0;
        n = 0;
        cyc = 0;
        stalled = 1'b0;
        prev = '0;
        while (n < 16 && cyc < 400) begin
            chk({name, ":valid"}, 64'(bus.subkey_valid), 64'd1);
            if (bus.subkey_valid !== 1'b1) break;
            chk({name, ":key_ready_run"}, 64'(bus.key_ready), 64'd0);
            chk({name, ":idx"}, 64'(bus.subkey_idx), 64'(n));
            if (stalled) chk({name, ":stall_stable"}, 64'(bus.subkey), 64'(prev));
            rdy = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.subkey_ready = rdy;
            if (rdy) begin
                chk({name, ":subkey"}, 64'(bus.subkey), 64'(exp_k[n]));
                got_k[n] = bus.subkey;
                n++;
            end
            prev = bus.subkey;
            stalled = !rdy;
            @(negedge clk);
            cyc++;
        end
        chk({name, ":xfer_count"}, 64'(n), 64'd16);
        bus.subkey_ready = 1'b0;
        chk({name, ":done"}, 64'(bus.done), 64'd1);
        chk({name, ":valid_after"}, 64'(bus.subkey_valid), 64'd0);
        chk({name, ":ready_in_done"}, 64'(bus.key_ready), 64'd1);
        $display("key %s %h: %0d subkeys in %0d cycles, K16=%h K1=%h",
                 name, key, n, cyc, got_k[0], got_k[15]);
        if (!hold) begin
            @(negedge clk);
            chk({name, ":done_pulse"}, 64'(bus.done), 64'd0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.key_in = '0;
        bus.key_valid = 1'b0;
        bus.subkey_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("rst:key_ready", 64'(bus.key_ready), 64'd1);
        chk("rst:valid", 64'(bus.subkey_valid), 64'd0);
        chk("rst:done", 64'(bus.done), 64'd0);
        chk("rst:idx", 64'(bus.subkey_idx), 64'd0);
        chk("rst:subkey", 64'(bus.subkey), 64'd0);
        $display("reset: key_ready=%b valid=%b subkey=%h", bus.key_ready, bus.subkey_valid, bus.subkey);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Textbook key, always-ready consumer.
        run_key("classic", 64'h133457799BBCDFF1, 1'b0, 1'b0, '0);
        chk("classic:K16", 64'(got_k[0]), 64'h0000CB3D8B0E17F5);
        chk("classic:K2", 64'(got_k[14]), 64'h000079AED9DBC9E5);
        chk("classic:K1", 64'(got_k[15]), 64'h00001B02EFFC7072);

        // Zero key and parity-only key give all-zero subkeys.
        run_key("zero", 64'h0000000000000000, 1'b0, 1'b0, '0);
        run_key("parity", 64'h0101010101010101, 1'b0, 1'b0, '0);
        chk("parity:K16", 64'(got_k[0]), 64'd0);

        // Same key with a stalling consumer.
        run_key("classic_stall", 64'h133457799BBCDFF1, 1'b1, 1'b0, '0);
        chk("classic_stall:K1", 64'(got_k[15]), 64'h00001B02EFFC7072);

        // Random keys against the encrypt-direction model.
        for (int i = 0; i < 3; i++) begin
            run_key("random", {$urandom, $urandom}, 1'b1, 1'b0, '0);
        end

        // Reset in the middle of a sequence at index 7.
        bus.key_in = 64'h0E329232EA6D0D73;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.subkey_ready = 1'b1;
        repeat (7) @(negedge clk);
        chk("midrst:idx7", 64'(bus.subkey_idx), 64'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst:key_ready", 64'(bus.key_ready), 64'd1);
        chk("midrst:valid", 64'(bus.subkey_valid), 64'd0);
        chk("midrst:done", 64'(bus.done), 64'd0);
        chk("midrst:idx", 64'(bus.subkey_idx), 64'd0);
        $display("mid-sequence reset: key_ready=%b valid=%b idx=%0d", bus.key_ready, bus.subkey_valid, bus.subkey_idx);
        bus.subkey_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_key("after_rst", 64'h0E329232EA6D0D73, 1'b0, 1'b0, '0);

        // key_valid held high: RUN-time key ignored, next key taken in the done cycle.
        run_key("hold_a", 64'hAABB09182736CCDD, 1'b0, 1'b1, 64'hFFEEDDCCBBAA9988);
        run_key("hold_b", 64'h0123456789ABCDEF, 1'b1, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
